// File: rtl/pixel_seq_ctrl.sv
// pixel_seq_ctrl: frame sequencer for a 4-pixel sensor array.
// Runs erase -> expose -> convert (256-step ramp) -> read12 -> read34
// per frame and holds an adjustable exposure setting.
// Ports:
//   clk, reset (async, active-high)
//   start, exp_inc, exp_dec   : frame request and exposure adjust
//   erase, expose, convert,
//   read12, read34            : one-hot pixel array strobes
//   adc_count[7:0]            : ramp value during convert
//   exp_time[4:0]             : current exposure length in cycles
//   busy, frame_done          : status
// Option: define AUTO_REPEAT_EN to loop frames continuously after one
// start; exposure adjusts are then taken in the frame_done cycle.
module pixel_seq_ctrl #(
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_DEFAULT  = 16,
    parameter int EXP_MIN      = 2,
    parameter int EXP_MAX      = 30,
    parameter int READ_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       exp_inc,
    input  logic       exp_dec,
    output logic       erase,
    output logic       expose,
    output logic       convert,
    output logic       read12,
    output logic       read34,
    output logic [7:0] adc_count,
    output logic [4:0] exp_time,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_READ12  = 3'd4;
    localparam logic [2:0] S_READ34  = 3'd5;

    localparam logic [15:0] ERASE_LAST = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] READ_LAST  = 16'(READ_CYCLES - 1);
    localparam logic [4:0]  EXP_DEF_V  = 5'(EXP_DEFAULT);
    localparam logic [4:0]  EXP_MIN_V  = 5'(EXP_MIN);
    localparam logic [4:0]  EXP_MAX_V  = 5'(EXP_MAX);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [15:0] exp_last;
    logic        adj_window;

    assign exp_last = {11'd0, exp_time} - 16'd1;

    // Window in which exposure adjust requests are accepted.
`ifdef AUTO_REPEAT_EN
    assign adj_window = frame_done;
`else
    assign adj_window = (state == S_IDLE);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 16'd0;
            adc_count  <= 8'd0;
            exp_time   <= EXP_DEF_V;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cnt        <= cnt + 16'd1;

            // Simultaneous inc and dec cancel out.
            if (adj_window && (exp_inc != exp_dec)) begin
                if (exp_inc && exp_time < EXP_MAX_V)
                    exp_time <= exp_time + 5'd1;
                else if (exp_dec && exp_time > EXP_MIN_V)
                    exp_time <= exp_time - 5'd1;
            end

            case (state)
                S_IDLE: begin
                    cnt <= 16'd0;
                    if (start)
                        state <= S_ERASE;
                end
                S_ERASE: begin
                    if (cnt == ERASE_LAST) begin
                        state <= S_EXPOSE;
                        cnt   <= 16'd0;
                    end
                end
                S_EXPOSE: begin
                    if (cnt == exp_last) begin
                        state     <= S_CONVERT;
                        cnt       <= 16'd0;
                        adc_count <= 8'd0;
                    end
                end
                S_CONVERT: begin
                    // The ramp itself times the phase; it saturates at
                    // 255 and holds until the next convert entry.
                    if (adc_count == 8'hFF) begin
                        state <= S_READ12;
                        cnt   <= 16'd0;
                    end else begin
                        adc_count <= adc_count + 8'd1;
                    end
                end
                S_READ12: begin
                    if (cnt == READ_LAST) begin
                        state <= S_READ34;
                        cnt   <= 16'd0;
                    end
                end
                S_READ34: begin
                    if (cnt == READ_LAST) begin
                        frame_done <= 1'b1;
                        cnt        <= 16'd0;
`ifdef AUTO_REPEAT_EN
                        state      <= S_ERASE;
`else
                        state      <= S_IDLE;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    // Moore decode straight from the state register.
    assign erase   = (state == S_ERASE);
    assign expose  = (state == S_EXPOSE);
    assign convert = (state == S_CONVERT);
    assign read12  = (state == S_READ12);
    assign read34  = (state == S_READ34);
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// tb_pixel_seq_ctrl: directed self-checking bench for pixel_seq_ctrl.
// Each task drives one scenario and checks its results inline.
module tb_pixel_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       exp_inc;
    logic       exp_dec;
    logic       erase;
    logic       expose;
    logic       convert;
    logic       read12;
    logic       read34;
    logic [7:0] adc_count;
    logic [4:0] exp_time;
    logic       busy;
    logic       frame_done;

    int checks;
    int errors;

    pixel_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .exp_inc    (exp_inc),
        .exp_dec    (exp_dec),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read12     (read12),
        .read34     (read34),
        .adc_count  (adc_count),
        .exp_time   (exp_time),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one frame from the current negedge (first ERASE cycle
    // expected) until frame_done is seen, then checks phase lengths.
    task automatic measure_frame(input int exp_len, input string tag);
        int n_er, n_ex, n_cv, n_r12, n_r34, n_busy;
        int adc_bad, hot_bad, done_seen;
        int strobes;
        n_er = 0; n_ex = 0; n_cv = 0; n_r12 = 0; n_r34 = 0; n_busy = 0;
        adc_bad = 0; hot_bad = 0; done_seen = 0;
        for (int i = 0; i < 600; i++) begin
            if (frame_done) begin
                done_seen = 1;
                break;
            end
            strobes = int'(erase) + int'(expose) + int'(convert)
                    + int'(read12) + int'(read34);
            if (busy) n_busy++;
            if (busy && strobes != 1) hot_bad++;
            if (!busy && strobes != 0) hot_bad++;
            if (erase) n_er++;
            if (expose) n_ex++;
            if (convert) begin
                if (adc_count !== 8'(n_cv)) adc_bad++;
                n_cv++;
            end
            if (read12) n_r12++;
            if (read34) n_r34++;
            @(negedge clk);
        end
        checks++;
        if (done_seen !== 1) begin
            errors++;
            $display("FAIL %s frame_done timeout: got %0d want 1", tag, done_seen);
        end
        checks++;
        if (n_er !== 5) begin
            errors++;
            $display("FAIL %s erase_len: got %0d want 5", tag, n_er);
        end
        checks++;
        if (n_ex !== exp_len) begin
            errors++;
            $display("FAIL %s expose_len: got %0d want %0d", tag, n_ex, exp_len);
        end
        checks++;
        if (n_cv !== 256) begin
            errors++;
            $display("FAIL %s convert_len: got %0d want 256", tag, n_cv);
        end
        checks++;
        if (n_r12 !== 1 || n_r34 !== 1) begin
            errors++;
            $display("FAIL %s read_len: got %0d/%0d want 1/1", tag, n_r12, n_r34);
        end
        checks++;
        if (n_busy !== 263 + exp_len) begin
            errors++;
            $display("FAIL %s busy_len: got %0d want %0d", tag, n_busy, 263 + exp_len);
        end
        checks++;
        if (adc_bad !== 0 || hot_bad !== 0) begin
            errors++;
            $display("FAIL %s adc/onehot: got %0d/%0d bad want 0/0", tag, adc_bad, hot_bad);
        end
        checks++;
        if (busy !== 1'b0 || adc_count !== 8'hFF) begin
            errors++;
            $display("FAIL %s done_state: got busy=%b adc=%0d want 0/255", tag, busy, adc_count);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: got %b want 0", tag, frame_done);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; exp_inc = 1'b0; exp_dec = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({erase, expose, convert, read12, read34, busy, frame_done} !== 7'b0
            || adc_count !== 8'd0 || exp_time !== 5'd16) begin
            errors++;
            $display("FAIL reset_state: got str=%b adc=%0d exp=%0d want 0/0/16",
                {erase, expose, convert, read12, read34, busy, frame_done},
                adc_count, exp_time);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_frame();
        pulse_start();
        checks++;
        if (erase !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: got erase=%b want 1", erase);
        end
        measure_frame(16, "frame16");
    endtask

    task automatic test_start_adjust();
        start = 1'b1; exp_inc = 1'b1;
        @(negedge clk);
        start = 1'b0; exp_inc = 1'b0;
        checks++;
        if (exp_time !== 5'd17) begin
            errors++;
            $display("FAIL start_adj_exp: got %0d want 17", exp_time);
        end
        measure_frame(17, "frame17");
    endtask

    task automatic test_exp_saturate();
        for (int i = 0; i < 20; i++) begin
            exp_inc = 1'b1;
            @(negedge clk);
            exp_inc = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (exp_time !== 5'd30) begin
            errors++;
            $display("FAIL exp_sat_max: got %0d want 30", exp_time);
        end
        for (int i = 0; i < 40; i++) begin
            exp_dec = 1'b1;
            @(negedge clk);
            exp_dec = 1'b0;
        end
        checks++;
        if (exp_time !== 5'd2) begin
            errors++;
            $display("FAIL exp_sat_min: got %0d want 2", exp_time);
        end
        pulse_start();
        measure_frame(2, "frame2");
    endtask

    task automatic test_exp_both_and_ignore();
        exp_inc = 1'b1;
        repeat (3) @(negedge clk);
        exp_inc = 1'b0;
        checks++;
        if (exp_time !== 5'd5) begin
            errors++;
            $display("FAIL exp_inc3: got %0d want 5", exp_time);
        end
        exp_inc = 1'b1; exp_dec = 1'b1;
        repeat (4) @(negedge clk);
        exp_inc = 1'b0; exp_dec = 1'b0;
        checks++;
        if (exp_time !== 5'd5) begin
            errors++;
            $display("FAIL exp_both: got %0d want 5", exp_time);
        end
        pulse_start();
        for (int i = 0; i < 100 && !convert; i++) @(negedge clk);
        exp_inc = 1'b1; start = 1'b1;
        repeat (10) @(negedge clk);
        exp_inc = 1'b0; start = 1'b0;
        exp_dec = 1'b1;
        repeat (5) @(negedge clk);
        exp_dec = 1'b0;
        checks++;
        if (exp_time !== 5'd5 || convert !== 1'b1) begin
            errors++;
            $display("FAIL exp_ignore_busy: got exp=%0d conv=%b want 5/1", exp_time, convert);
        end
        for (int i = 0; i < 400 && !frame_done; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_time !== 5'd5) begin
            errors++;
            $display("FAIL start_ignore_busy: got busy=%b exp=%0d want 0/5", busy, exp_time);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        int found;
        pulse_start();
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (convert && adc_count == 8'd100) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (found !== 1) begin
            errors++;
            $display("FAIL reach_adc100: got %0d want 1", found);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({erase, expose, convert, read12, read34, busy, frame_done} !== 7'b0
            || adc_count !== 8'd0 || exp_time !== 5'd16) begin
            errors++;
            $display("FAIL async_reset: got str=%b adc=%0d exp=%0d want 0/0/16",
                {erase, expose, convert, read12, read34, busy, frame_done},
                adc_count, exp_time);
        end
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (frame_done || busy) done_cnt++;
            @(negedge clk);
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d active cycles want 0", done_cnt);
        end
        pulse_start();
        measure_frame(16, "post_reset");
    endtask

    task automatic test_back_to_back();
        int found;
        start = 1'b1;
        @(negedge clk);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (read34) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (found !== 1 || busy !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got found=%0d busy=%b done=%b want 1/0/1",
                found, busy, frame_done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (erase !== 1'b1) begin
            errors++;
            $display("FAIL b2b_erase: got erase=%b want 1", erase);
        end
        measure_frame(16, "b2b_frame2");
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int dones;
        int drops;
        pulse_start();
        dones = 0; drops = 0;
        for (int i = 0; i < 3 * 279; i++) begin
            if (frame_done) dones++;
            if (!busy) drops++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 2 || drops !== 0) begin
            errors++;
            $display("FAIL auto_repeat: got dones=%0d drops=%0d want 2/0", dones, drops);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; exp_inc = 1'b0; exp_dec = 1'b0;
        @(negedge clk);
        test_reset();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`else
        test_frame();
        test_start_adjust();
        test_exp_saturate();
        test_exp_both_and_ignore();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_seq_ctrl.md
PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

Interface
REQ-001 Parameter ERASE_CYCLES, default 5, number of clock cycles erase is held high per frame.
REQ-002 Parameter EXP_DEFAULT, default 16, exposure length in cycles after reset.
REQ-003 Parameter EXP_MIN, default 2; parameter EXP_MAX, default 30; exposure saturation limits.
REQ-004 Parameter READ_CYCLES, default 1, cycles each of read12/read34 is held high.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request one frame; sampled only in IDLE.
REQ-008 exp_inc  input  1  increase exposure by 1 cycle; sampled only in IDLE.
REQ-009 exp_dec  input  1  decrease exposure by 1 cycle; sampled only in IDLE.
REQ-010 erase  output  1  pixel array erase strobe.
REQ-011 expose  output  1  pixel array expose strobe.
REQ-012 convert  output  1  pixel array convert (ramp compare) phase.
REQ-013 read12  output  1  enables pixel 1/2 data buses.
REQ-014 read34  output  1  enables pixel 3/4 data buses.
REQ-015 adc_count  output  8  ramp counter value driven to the pixel comparators during convert.
REQ-016 exp_time  output  5  current exposure setting in cycles.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 frame_done  output  1  one-cycle pulse at frame completion.

Function
REQ-019 The FSM SHALL have states IDLE, ERASE, EXPOSE, CONVERT, READ12, READ34; all outputs are registered, Moore-decoded.
REQ-020 In IDLE, start=1 at rising edge k SHALL put the FSM in ERASE with erase=1 from edge k onward.
REQ-021 ERASE SHALL last exactly ERASE_CYCLES cycles, then EXPOSE for exactly exp_time cycles, then CONVERT for exactly 256 cycles, then READ12 and READ34 for READ_CYCLES cycles each, then IDLE.
REQ-022 Exactly one of erase/expose/convert/read12/read34 SHALL be high in non-IDLE states; all low in IDLE.
REQ-023 adc_count SHALL be 0 on CONVERT entry, increment by 1 each CONVERT cycle reaching 255 on the last, and hold 255 thereafter until the next CONVERT entry resets it to 0; no wrap to 0 within CONVERT.
REQ-024 frame_done SHALL pulse high for the single cycle following the last READ34 cycle (first IDLE cycle).
REQ-025 exp_inc alone in IDLE SHALL increment exp_time, saturating at EXP_MAX; exp_dec alone SHALL decrement, saturating at EXP_MIN.
REQ-026 exp_inc and exp_dec both high SHALL leave exp_time unchanged.
REQ-027 exp_inc/exp_dec/start outside IDLE SHALL be ignored; exp_time SHALL not change during a frame.
REQ-028 start together with exp_inc/exp_dec in IDLE SHALL start the frame and apply the adjust; the new exp_time SHALL be used by that frame.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, all strobes 0, adc_count 0, busy 0, frame_done 0, exp_time EXP_DEFAULT, independent of clk.
REQ-030 Reset mid-frame SHALL abort the frame without a frame_done pulse; after release the FSM waits for start.

Configuration
REQ-031 With AUTO_REPEAT_EN defined, leaving READ34 SHALL go directly to ERASE (frame_done still pulses one cycle, busy stays high), and exp_inc/exp_dec SHALL be sampled in the frame_done cycle instead of IDLE; without it, leaving READ34 goes to IDLE and requires a new start.

Verification
REQ-032 Reset, start pulse -> erase 5 cycles, expose 16, convert 256 with adc_count 0..255, read12 1, read34 1, frame_done 1 cycle; total 279 busy cycles.
REQ-033 20 exp_inc pulses in IDLE -> exp_time saturates at 30; 40 exp_dec pulses -> saturates at 2; next frame expose lasts 2 cycles.
REQ-034 exp_inc and exp_dec together -> exp_time unchanged; exp_inc during CONVERT -> ignored.
REQ-035 Assert reset at CONVERT cycle 100 -> all outputs 0 same cycle, no frame_done, exp_time 16, start afterwards runs full frame.
REQ-036 Start held high continuously (no AUTO_REPEAT_EN) -> back-to-back frames with exactly one IDLE cycle between READ34 and ERASE.
REQ-037 AUTO_REPEAT_EN defined, one start -> READ34 followed immediately by ERASE, frame_done pulses once per frame, busy never drops.
